upsampling_controller: RTL
==========================

Name: upsampling_controller

Overview:
- Sequencing controller that drives the upsampling datapath for a 2x horizontal and 2x vertical upsample of an 8-bit grayscale image.
- Issues source-memory reads, controls the datapath's 48-bit three-word window, sets the edge/phase mux selects, and generates destination write addresses and strobes.
- Sits directly upstream of the datapath. Its outputs connect one-to-one to the datapath's r_addr, w_addr, shift_enb, mux_*_sel and end_of_pixel inputs.
- Memory is 16-bit wide, two pixels per word, row-major.

Parameters:
- IMG_W, 256, source pixels per row; must be even and >= 4. WPR = IMG_W/2 words per row.
- IMG_H, 256, source rows; must be >= 1.
- SRC_BASE, 18'h00000, word address of source pixel (0,0).
- DST_BASE, 18'h08000, word address of output pixel (0,0). The output image is 2*IMG_W x 2*IMG_H pixels, with IMG_W words per output row.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a frame; ignored unless the block is IDLE
- rd_en  out  1  source read strobe; r_data returns valid exactly 1 cycle later
- r_addr  out  18  source word address
- shift_enb  out  1  datapath window shift, asserted in the cycle r_data is valid
- wr_en  out  1  destination write strobe
- w_addr  out  18  destination word address
- mux_first1_sel  out  2  left-edge select: 2'b01 when k==0, otherwise 2'b00
- mux_end1_sel  out  2  right-edge select: 2'b01 when k==WPR-1, otherwise 2'b00
- mux_first2_sel  out  1  output word half: phase[0]
- mux_end2_sel  out  1  output row parity: phase[1]
- end_of_pixel  out  1  pulse on the last write of each source word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: state=IDLE and counters r=0, k=0, phase=0. Every output is 0 while rst is high and in the first cycle after release. Assertion of rst at any time aborts the frame immediately with no further writes.
- All outputs are registered or decoded from registered state only. No combinational path exists from start to any output.
- Window convention: after the shifts of the prefill, the datapath holds [31:16]=word k (centre) and [15:0]=word k+1.
- FSM states and transitions:
  - IDLE: on start, go to PRE0 with r=0.
  - PRE0: rd_en=1, r_addr=SRC_BASE + r*WPR. Go to PRE1.
  - PRE1: rd_en=1, r_addr=SRC_BASE + r*WPR + 1, shift_enb=1. Go to PRE2.
  - PRE2: shift_enb=1, k=0, phase=0. Go to WR.
  - WR: runs 4 cycles with phase 0..3 and wr_en=1.
    - w_addr = DST_BASE + (2r + phase[1])*IMG_W + 2k + phase[0].
    - On phase 3: end_of_pixel=1. If k+2 < WPR, also rd_en=1 with r_addr=SRC_BASE + r*WPR + k + 2.
    - After phase 3: if k < WPR-1, go to ADV; otherwise go to ROWEND.
  - ADV: shift_enb=1 unconditionally. The slot that receives undefined data is only used when mux_end1_sel=01. Then k=k+1, phase=0, go to WR.
  - ROWEND: if r == IMG_H-1, go to FIN; otherwise r=r+1 and go to PRE0.
  - FIN: done=1. Go to IDLE.
- Mux selects are valid whenever wr_en=1. Outside writes they hold their last values.
- Cycles per source row: 5*WPR + 3. Frame latency from start to done: IMG_H*(5*WPR+3) + 2 cycles.
- rd_en and wr_en are never asserted in the same cycle, except WR phase 3 when a read is due.
- A start pulse while busy has no effect.
- Address arithmetic is unsigned, 18-bit, modulo 2^18. Wrap is not checked.

Decomposition:
- Package upsampling_pkg holds:
  - state enum: IDLE, PRE0, PRE1, PRE2, WR, ADV, ROWEND, FIN
  - ADDR_W=18, DATA_W=16
  - constants SEL_NORMAL=2'b00 and SEL_EDGE=2'b01
- Sub-module upsampling_addr_gen owns the r, k and phase counters and the r_addr/w_addr computation. The controller holds the FSM only.

Test Plan (IMG_W=4, IMG_H=2, SRC_BASE=0, DST_BASE=18'h100, so WPR=2):
- Reset mid-WR (assert rst at phase 2): all outputs 0 the same cycle, state IDLE, no further wr_en.
- Single frame: start at cycle 0 -> done exactly 2*13+2=28 cycles later. Exactly 16 wr_en pulses, 4 rd_en pulses, 4 end_of_pixel pulses.
- Address sequence, row 0:
  - r_addr = 0, 1.
  - w_addr = 100, 101, 104, 105 for k=0, then 102, 103, 106, 107 for k=1.
  - Row 1 w_addr starts at 108.
- Edge selects: mux_first1_sel=01 only during k=0 writes and mux_end1_sel=01 only during k=1 writes. With WPR=2 there is no WR phase-3 read in either step.
- Start while busy: extra start pulse at cycle 10 -> no effect, done still at cycle 28 and exactly one done pulse.
- Back-to-back frames: start in the cycle after done -> second frame identical to the first. Window shift_enb count per row is 3 (PRE1, PRE2, ADV).

Source files
------------

// File: rtl/upsampling_pkg.sv
// Shared types and constants for the 2x2 upsampling controller.
//   state_t    : controller FSM states
//   ADDR_W     : memory word-address width
//   DATA_W     : memory word width (two 8-bit pixels)
//   SEL_*      : edge-mux select encodings driven to the datapath
package upsampling_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    localparam logic [1:0] SEL_NORMAL = 2'b00;
    localparam logic [1:0] SEL_EDGE   = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        PRE0,
        PRE1,
        PRE2,
        WR,
        ADV,
        ROWEND,
        FIN
    } state_t;

endpackage

// File: rtl/upsampling_addr_gen.sv
// Row / word / phase counters and source/destination address arithmetic.
//   i_row_clr   : restart at row 0 (frame start)
//   i_step_clr  : restart at word 0, phase 0 (row prefill done)
//   i_phase_inc : advance the write phase (wraps 3 -> 0)
//   i_k_inc     : move to the next source word
//   i_r_inc     : move to the next source row
//   i_rd_sel    : read offset in row: 0 -> word 0, 1 -> word 1, 2 -> word k+2
//   o_phase     : current write phase
//   o_k_first / o_k_last / o_r_last / o_rd_due : position flags for the FSM
//   o_rd_addr / o_wr_addr : combinational addresses, registered by the top
module upsampling_addr_gen
    import upsampling_pkg::*;
#(
    parameter int                IMG_W    = 256,
    parameter int                IMG_H    = 256,
    parameter logic [ADDR_W-1:0] SRC_BASE = 18'h00000,
    parameter logic [ADDR_W-1:0] DST_BASE = 18'h08000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_row_clr,
    input  logic              i_step_clr,
    input  logic              i_phase_inc,
    input  logic              i_k_inc,
    input  logic              i_r_inc,
    input  logic [1:0]        i_rd_sel,
    output logic [1:0]        o_phase,
    output logic              o_k_first,
    output logic              o_k_last,
    output logic              o_r_last,
    output logic              o_rd_due,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [ADDR_W-1:0] o_wr_addr
);

    localparam logic [ADDR_W-1:0] WPR    = ADDR_W'(IMG_W / 2);
    localparam logic [ADDR_W-1:0] IMG_WA = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_R = ADDR_W'(IMG_H - 1);

    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_k;
    logic [1:0]        r_phase;
    logic [ADDR_W-1:0] w_row_base;
    logic [ADDR_W-1:0] w_out_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row   <= '0;
            r_k     <= '0;
            r_phase <= '0;
        end else begin
            if (i_row_clr)
                r_row <= '0;
            else if (i_r_inc)
                r_row <= r_row + 1'b1;

            if (i_step_clr) begin
                r_k     <= '0;
                r_phase <= '0;
            end else if (i_k_inc) begin
                r_k     <= r_k + 1'b1;
                r_phase <= '0;
            end else if (i_phase_inc) begin
                r_phase <= r_phase + 2'd1;
            end
        end
    end

    assign o_phase   = r_phase;
    assign o_k_first = (r_k == '0);
    assign o_k_last  = (r_k == WPR - 1'b1);
    assign o_r_last  = (r_row == LAST_R);
    assign o_rd_due  = ((r_k + ADDR_W'(2)) < WPR);

    assign w_row_base = SRC_BASE + r_row * WPR;

    always_comb begin
        o_rd_addr = w_row_base;
        case (i_rd_sel)
            2'd1:    o_rd_addr = w_row_base + ADDR_W'(1);
            2'd2:    o_rd_addr = w_row_base + r_k + ADDR_W'(2);
            default: o_rd_addr = w_row_base;
        endcase
    end

    // Each source row expands to two output rows; phase[1] picks the lower one,
    // phase[0] picks the right-hand word of the pixel pair.
    assign w_out_row = (r_row << 1) + ADDR_W'(r_phase[1]);
    assign o_wr_addr = DST_BASE + w_out_row * IMG_WA + (r_k << 1) + ADDR_W'(r_phase[0]);

endmodule

// File: rtl/upsampling_controller.sv
// Sequencing FSM for the 2x2 upsampling datapath.
//   clk, rst         : clock, async active-high reset
//   i_start          : frame start pulse (honoured only when idle)
//   o_rd_en/o_r_addr : source read strobe and word address
//   o_shift_enb      : datapath window shift (aligned with returning read data)
//   o_wr_en/o_w_addr : destination write strobe and word address
//   o_mux_*_sel      : edge and phase selects for the datapath
//   o_end_of_pixel   : last write for the current source word
//   o_busy / o_done  : frame in progress / frame complete pulse
// Every output is a register fed by a decode of the current state, so the
// whole output schedule trails the state sequence by one cycle.
module upsampling_controller
    import upsampling_pkg::*;
#(
    parameter int                IMG_W    = 256,
    parameter int                IMG_H    = 256,
    parameter logic [ADDR_W-1:0] SRC_BASE = 18'h00000,
    parameter logic [ADDR_W-1:0] DST_BASE = 18'h08000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_r_addr,
    output logic              o_shift_enb,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic [1:0]        o_mux_first1_sel,
    output logic [1:0]        o_mux_end1_sel,
    output logic              o_mux_first2_sel,
    output logic              o_mux_end2_sel,
    output logic              o_end_of_pixel,
    output logic              o_busy,
    output logic              o_done
);

    state_t            r_state, w_next;
    logic [1:0]        w_phase;
    logic              w_k_first, w_k_last, w_r_last, w_rd_due;
    logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;
    logic              w_row_clr, w_step_clr, w_phase_inc, w_k_inc, w_r_inc;
    logic [1:0]        w_rd_sel;
    logic              w_rd, w_shift, w_wr, w_eop, w_busy, w_done;

    upsampling_addr_gen #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE)
    ) u_addr (
        .clk        (clk),
        .rst        (rst),
        .i_row_clr  (w_row_clr),
        .i_step_clr (w_step_clr),
        .i_phase_inc(w_phase_inc),
        .i_k_inc    (w_k_inc),
        .i_r_inc    (w_r_inc),
        .i_rd_sel   (w_rd_sel),
        .o_phase    (w_phase),
        .o_k_first  (w_k_first),
        .o_k_last   (w_k_last),
        .o_r_last   (w_r_last),
        .o_rd_due   (w_rd_due),
        .o_rd_addr  (w_rd_addr),
        .o_wr_addr  (w_wr_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = PRE0;
            PRE0:    w_next = PRE1;
            PRE1:    w_next = PRE2;
            PRE2:    w_next = WR;
            WR:      if (w_phase == 2'd3) w_next = w_k_last ? ROWEND : ADV;
            ADV:     w_next = WR;
            ROWEND:  w_next = w_r_last ? FIN : PRE0;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_row_clr   = 1'b0;
        w_step_clr  = 1'b0;
        w_phase_inc = 1'b0;
        w_k_inc     = 1'b0;
        w_r_inc     = 1'b0;
        w_rd_sel    = 2'd0;
        w_rd        = 1'b0;
        w_shift     = 1'b0;
        w_wr        = 1'b0;
        w_eop       = 1'b0;
        w_done      = 1'b0;
        w_busy      = (r_state != IDLE);
        case (r_state)
            IDLE:   w_row_clr = i_start;
            PRE0:   w_rd = 1'b1;
            PRE1: begin
                w_rd     = 1'b1;
                w_rd_sel = 2'd1;
                w_shift  = 1'b1;
            end
            PRE2: begin
                w_shift    = 1'b1;
                w_step_clr = 1'b1;
            end
            WR: begin
                w_wr        = 1'b1;
                w_phase_inc = 1'b1;
                if (w_phase == 2'd3) begin
                    w_eop    = 1'b1;
                    w_rd     = w_rd_due;
                    w_rd_sel = 2'd2;
                end
            end
            // The last ADV of a row shifts in an undefined word; the datapath
            // only consumes that slot under the right-edge select.
            ADV: begin
                w_shift = 1'b1;
                w_k_inc = 1'b1;
            end
            ROWEND: w_r_inc = !w_r_last;
            FIN:    w_done  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_en          <= 1'b0;
            o_r_addr         <= '0;
            o_shift_enb      <= 1'b0;
            o_wr_en          <= 1'b0;
            o_w_addr         <= '0;
            o_mux_first1_sel <= SEL_NORMAL;
            o_mux_end1_sel   <= SEL_NORMAL;
            o_mux_first2_sel <= 1'b0;
            o_mux_end2_sel   <= 1'b0;
            o_end_of_pixel   <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            o_rd_en        <= w_rd;
            o_shift_enb    <= w_shift;
            o_wr_en        <= w_wr;
            o_end_of_pixel <= w_eop;
            o_busy         <= w_busy;
            o_done         <= w_done;
            if (w_rd)
                o_r_addr <= w_rd_addr;
            // Addresses and selects hold between writes.
            if (w_wr) begin
                o_w_addr         <= w_wr_addr;
                o_mux_first1_sel <= w_k_first ? SEL_EDGE : SEL_NORMAL;
                o_mux_end1_sel   <= w_k_last  ? SEL_EDGE : SEL_NORMAL;
                o_mux_first2_sel <= w_phase[0];
                o_mux_end2_sel   <= w_phase[1];
            end
        end
    end

endmodule
